// File: rtl/digit_tube_scan_pkg.sv
// digit_tube_scan_pkg
// Shared constants for the multiplexed 7-segment tube driver and any other
// display block that needs the same segment encoding.
//
// Contents:
//   SEG_0 .. SEG_F    active-low segment codes for hex digits,
//                     bit7 = dp, bits6..0 = g,f,e,d,c,b,a
//   SEG_OFF           all segments dark (dp included)
//   DIGIT_OFF         all digit enables inactive (active-low)
//   DEFAULT_SCAN_DIV  default clock cycles per digit slot
package digit_tube_scan_pkg;

    // Active-low segment codes; dp (bit 7) is held high so it never lights.
    localparam logic [7:0] SEG_0 = 8'hC0;
    localparam logic [7:0] SEG_1 = 8'hF9;
    localparam logic [7:0] SEG_2 = 8'hA4;
    localparam logic [7:0] SEG_3 = 8'hB0;
    localparam logic [7:0] SEG_4 = 8'h99;
    localparam logic [7:0] SEG_5 = 8'h92;
    localparam logic [7:0] SEG_6 = 8'h82;
    localparam logic [7:0] SEG_7 = 8'hF8;
    localparam logic [7:0] SEG_8 = 8'h80;
    localparam logic [7:0] SEG_9 = 8'h90;
    localparam logic [7:0] SEG_A = 8'h88;
    localparam logic [7:0] SEG_B = 8'h83;
    localparam logic [7:0] SEG_C = 8'hC6;
    localparam logic [7:0] SEG_D = 8'hA1;
    localparam logic [7:0] SEG_E = 8'h86;
    localparam logic [7:0] SEG_F = 8'h8E;

    // Dark patterns for the segment bus and the digit enable bus.
    localparam logic [7:0] SEG_OFF   = 8'hFF;
    localparam logic [7:0] DIGIT_OFF = 8'hFF;

    // One digit slot per 50k clocks gives a flicker-free refresh at 50 MHz.
    localparam int DEFAULT_SCAN_DIV = 50000;

endpackage

// File: rtl/digit_tube_scan_hex_to_seg.sv
// hex_to_seg
// Combinational hex nibble to active-low 7-segment decoder.
//
// Ports:
//   nibble  in   4  hex value to display
//   seg     out  8  active-low segments, bit7 = dp (always off), bits6..0 = g..a
module hex_to_seg
    import digit_tube_scan_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [7:0] seg
);

    // Straight table lookup; every nibble value has a code, so the default
    // arm only exists to keep the block obviously latch-free.
    always_comb begin
        seg = SEG_OFF;
        case (nibble)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
            default: seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/digit_tube_scan.sv
// digit_tube_scan
// Drives an 8-digit multiplexed common-anode 7-segment tube from a 32-bit
// held register value, one hex digit at a time. A snapshot of din is taken
// only when a full frame wraps, so a store landing mid-frame never tears
// the displayed number.
//
// Parameters:
//   SCAN_DIV  clock cycles per digit slot (2 .. 2^20)
//   GUARD     dark cycles at the start of each slot to stop ghosting (< SCAN_DIV)
//   LZ_BLANK  1 = blank leading zero digits (digit 0 is always shown)
//
// Ports:
//   clk         in   1   system clock
//   reset       in   1   synchronous active-high reset
//   din         in   32  value from the upstream output register
//   en          in   1   scan enable; 0 = display dark and scan state frozen
//   digit_sel   out  8   active-low digit enables, bit k = digit k (0 rightmost)
//   seg         out  8   active-low segments, bit7 = dp, bits6..0 = g..a
//   frame_done  out  1   one-cycle pulse after a full 8-digit frame completes
module digit_tube_scan
    import digit_tube_scan_pkg::*;
#(
    parameter int SCAN_DIV = DEFAULT_SCAN_DIV,
    parameter int GUARD    = 2,
    parameter int LZ_BLANK = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] din,
    input  logic        en,
    output logic [7:0]  digit_sel,
    output logic [7:0]  seg,
    output logic        frame_done
);

    localparam int                 CNT_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [31:0]        GUARD_U  = 32'(GUARD);

    logic [CNT_W-1:0] cnt;
    logic [2:0]       idx;
    logic [31:0]      snap;

    logic             tick;
    logic             frame_wrap;
    logic             in_guard;
    logic [4:0]       bit_pos;
    logic [3:0]       nibble;
    logic [7:0]       hex_code;
    logic             upper_zero;
    logic             blank;
    logic [7:0]       sel_next;
    logic [7:0]       seg_next;

    // A slot ends on the last prescaler count; a frame ends when that
    // happens on the leftmost digit. Both require en, so dropping en on
    // the very cycle a slot would end simply freezes everything.
    assign tick       = en && (cnt == CNT_LAST);
    assign frame_wrap = tick && (idx == 3'd7);

    // Widen cnt to 32 bits so the guard compare works for any GUARD value.
    assign in_guard   = {{(32-CNT_W){1'b0}}, cnt} < GUARD_U;

    // Select the nibble belonging to the digit currently being scanned.
    assign bit_pos    = {idx, 2'b00};
    assign nibble     = snap[bit_pos +: 4];

    // A digit is a leading zero when it and everything to its left is zero.
    assign upper_zero = (snap >> bit_pos) == 32'd0;
    assign blank      = (LZ_BLANK != 0) && (idx != 3'd0) && upper_zero;

    hex_to_seg u_hex_to_seg (
        .nibble (nibble),
        .seg    (hex_code)
    );

    // Next-output decode from the current scan state. The tube stays dark
    // while disabled and during the guard window; a blanked digit keeps its
    // enable low so the scan pattern and brightness stay uniform.
    always_comb begin
        sel_next = DIGIT_OFF;
        seg_next = SEG_OFF;
        if (en && !in_guard) begin
            sel_next = ~(8'h01 << idx);
            seg_next = blank ? SEG_OFF : hex_code;
        end
    end

    // Prescaler, digit index, frame snapshot and the registered outputs.
    // Reset wins over everything, including a frame wrap in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt        <= '0;
            idx        <= 3'd0;
            snap       <= 32'd0;
            digit_sel  <= DIGIT_OFF;
            seg        <= SEG_OFF;
            frame_done <= 1'b0;
        end else begin
            digit_sel  <= sel_next;
            seg        <= seg_next;
            frame_done <= frame_wrap;
            if (en) begin
                cnt <= tick ? '0 : cnt + CNT_W'(1);
                if (tick) begin
                    idx <= idx + 3'd1;
                end
                if (frame_wrap) begin
                    snap <= din;
                end
            end
        end
    end

endmodule

// File: tb/tb_digit_tube_scan.sv
// tb_digit_tube_scan
// Directed bench for digit_tube_scan with SCAN_DIV=4, GUARD=1. Two copies of
// the design share all inputs: one without and one with leading-zero
// blanking, so every step checks both encodings against hand-computed codes.
// Each slot is 4 cycles: one dark guard cycle, then three cycles of the digit.
module tb_digit_tube_scan;

    logic        clk;
    logic        reset;
    logic [31:0] din;
    logic        en;
    logic [7:0]  sel0, seg0, sel1, seg1;
    logic        fd0, fd1;

    int vectors;
    int miscompares;
    int frameNo;

    digit_tube_scan #(.SCAN_DIV(4), .GUARD(1), .LZ_BLANK(0)) dut0 (
        .clk        (clk),
        .reset      (reset),
        .din        (din),
        .en         (en),
        .digit_sel  (sel0),
        .seg        (seg0),
        .frame_done (fd0)
    );

    digit_tube_scan #(.SCAN_DIV(4), .GUARD(1), .LZ_BLANK(1)) dut1 (
        .clk        (clk),
        .reset      (reset),
        .din        (din),
        .en         (en),
        .digit_sel  (sel1),
        .seg        (seg1),
        .frame_done (fd1)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive all inputs together, away from the sampling edge.
    task automatic applyStimulus(input logic r, input logic e, input logic [31:0] d);
        reset = r;
        en    = e;
        din   = d;
    endtask

    // Advance one clock and settle just after the edge.
    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Compare both instances' registered outputs with the expected values.
    task automatic checkOutput(input string tag, input logic [7:0] expSel,
                               input logic [7:0] expSeg0, input logic [7:0] expSeg1,
                               input logic expFd);
        vectors++;
        assert (sel0 === expSel) else begin
            miscompares++;
            $error("[TB] FAIL %s digit_sel(lz0) observed %h expected %h", tag, sel0, expSel);
        end
        vectors++;
        assert (sel1 === expSel) else begin
            miscompares++;
            $error("[TB] FAIL %s digit_sel(lz1) observed %h expected %h", tag, sel1, expSel);
        end
        vectors++;
        assert (seg0 === expSeg0) else begin
            miscompares++;
            $error("[TB] FAIL %s seg(lz0) observed %h expected %h", tag, seg0, expSeg0);
        end
        vectors++;
        assert (seg1 === expSeg1) else begin
            miscompares++;
            $error("[TB] FAIL %s seg(lz1) observed %h expected %h", tag, seg1, expSeg1);
        end
        vectors++;
        assert (fd0 === expFd) else begin
            miscompares++;
            $error("[TB] FAIL %s frame_done(lz0) observed %b expected %b", tag, fd0, expFd);
        end
        vectors++;
        assert (fd1 === expFd) else begin
            miscompares++;
            $error("[TB] FAIL %s frame_done(lz1) observed %b expected %b", tag, fd1, expFd);
        end
    endtask

    // Check the expected digit-k output of an in-slot cycle.
    task automatic checkDigit(input int k, input int c, input logic [63:0] codes0,
                              input logic [63:0] codes1, input logic expFd);
        logic [7:0] sel;
        sel = 8'h01 << k;
        sel = ~sel;
        checkOutput($sformatf("f%0d_d%0d_c%0d", frameNo, k, c), sel,
                    codes0[8*k +: 8], codes1[8*k +: 8], expFd);
    endtask

    // One full slot: dark guard cycle then three lit cycles; frame_done
    // rises together with the last lit cycle of digit 7.
    task automatic checkSlot(input int k, input logic [63:0] codes0, input logic [63:0] codes1);
        nextCycle();
        checkOutput($sformatf("f%0d_d%0d_guard", frameNo, k), 8'hFF, 8'hFF, 8'hFF, 1'b0);
        for (int c = 1; c < 4; c++) begin
            nextCycle();
            checkDigit(k, c, codes0, codes1, (k == 7) && (c == 3));
        end
    endtask

    // Per-digit codes, byte k = digit k, written digit 7 first.
    localparam logic [63:0] ZERO_LZ0 = 64'hC0_C0_C0_C0_C0_C0_C0_C0;
    localparam logic [63:0] ZERO_LZ1 = 64'hFF_FF_FF_FF_FF_FF_FF_C0;
    localparam logic [63:0] V89AB    = 64'h80_90_88_83_C6_A1_86_8E;
    localparam logic [63:0] V1234    = 64'hF9_A4_B0_99_92_82_F8_80;
    localparam logic [63:0] VA0_LZ0  = 64'hC0_C0_C0_C0_C0_C0_88_C0;
    localparam logic [63:0] VA0_LZ1  = 64'hFF_FF_FF_FF_FF_FF_88_C0;

    initial begin
        vectors     = 0;
        miscompares = 0;
        frameNo     = 0;

        // Reset state.
        applyStimulus(1'b1, 1'b0, 32'h0);
        nextCycle();
        checkOutput("reset", 8'hFF, 8'hFF, 8'hFF, 1'b0);

        // Frame 1 shows the zero snapshot; din is taken at its wrap.
        $display("[TB] frame 1: zero snapshot, din=89ABCDEF");
        applyStimulus(1'b0, 1'b1, 32'h89AB_CDEF);
        frameNo = 1;
        for (int k = 0; k < 8; k++) checkSlot(k, ZERO_LZ0, ZERO_LZ1);

        // Frame 2 shows 89ABCDEF; din changes right away but must not show.
        $display("[TB] frame 2: 89ABCDEF, din -> 12345678");
        applyStimulus(1'b0, 1'b1, 32'h1234_5678);
        frameNo = 2;
        for (int k = 0; k < 8; k++) checkSlot(k, V89AB, V89AB);

        // Frame 3 shows 12345678; din drops to zero mid-frame.
        $display("[TB] frame 3: 12345678, din -> 0 mid-frame");
        frameNo = 3;
        for (int k = 0; k < 4; k++) checkSlot(k, V1234, V1234);
        applyStimulus(1'b0, 1'b1, 32'h0);
        for (int k = 4; k < 8; k++) checkSlot(k, V1234, V1234);

        // Frame 4 is all zero; load the leading-zero test value.
        $display("[TB] frame 4: zero, din -> 000000A0");
        frameNo = 4;
        applyStimulus(1'b0, 1'b1, 32'h0000_00A0);
        for (int k = 0; k < 8; k++) checkSlot(k, ZERO_LZ0, ZERO_LZ1);

        // Frame 5 shows 000000A0 with a 10-cycle pause inside digit 3.
        $display("[TB] frame 5: 000000A0 with pause in digit 3");
        frameNo = 5;
        for (int k = 0; k < 3; k++) checkSlot(k, VA0_LZ0, VA0_LZ1);
        nextCycle();
        checkOutput("f5_d3_guard", 8'hFF, 8'hFF, 8'hFF, 1'b0);
        nextCycle();
        checkDigit(3, 1, VA0_LZ0, VA0_LZ1, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h0000_00A0);
        for (int p = 0; p < 10; p++) begin
            nextCycle();
            checkOutput($sformatf("f5_pause%0d", p), 8'hFF, 8'hFF, 8'hFF, 1'b0);
        end
        applyStimulus(1'b0, 1'b1, 32'h0000_00A0);
        nextCycle();
        checkDigit(3, 2, VA0_LZ0, VA0_LZ1, 1'b0);
        nextCycle();
        checkDigit(3, 3, VA0_LZ0, VA0_LZ1, 1'b0);
        for (int k = 4; k < 8; k++) checkSlot(k, VA0_LZ0, VA0_LZ1);

        // Frame 6: reset lands in the middle of digit 5.
        $display("[TB] frame 6: reset mid-frame at digit 5");
        frameNo = 6;
        for (int k = 0; k < 5; k++) checkSlot(k, VA0_LZ0, VA0_LZ1);
        nextCycle();
        checkOutput("f6_d5_guard", 8'hFF, 8'hFF, 8'hFF, 1'b0);
        nextCycle();
        checkDigit(5, 1, VA0_LZ0, VA0_LZ1, 1'b0);
        applyStimulus(1'b1, 1'b1, 32'h0000_00A0);
        nextCycle();
        checkOutput("f6_reset", 8'hFF, 8'hFF, 8'hFF, 1'b0);

        // Frame 7 restarts at digit 0 from a zero snapshot.
        $display("[TB] frame 7: restart after reset");
        applyStimulus(1'b0, 1'b1, 32'h0000_00A0);
        frameNo = 7;
        for (int k = 0; k < 8; k++) checkSlot(k, ZERO_LZ0, ZERO_LZ1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
